des_sbox_seq: RTL and testbench
===============================

DES_SBOX_SEQ -- requirements
Module: des_sbox_seq

Interface
REQ-001 SHALL have parameter DEFAULT_BLOCKING, default 1, meaning in_ready is low in every state except IDLE (value 0 reserved, not supported).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  48-bit S-box input block offered.
REQ-005 SHALL have port in_ready  output  1  block accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have port in_data  input  48  expanded-XOR-key block; group g (0..7) = in_data[47-6g -: 6].
REQ-007 SHALL have port out_valid  output  1  32-bit substituted result available.
REQ-008 SHALL have port out_ready  input  1  consumer takes result when out_valid and out_ready are both high at an edge.
REQ-009 SHALL have port out_data  output  32  result; nibble g = out_data[31-4g -: 4] = S(g+1) of group g.
REQ-010 SHALL have port busy  output  1  high in RUN or HOLD.

Function
REQ-011 SHALL time-share one selectable S-box lookup: one 6-bit group per cycle, eight cycles per block.
REQ-012 SHALL index each lookup as row = {b5,b0}, column = b4..b1 of the 6-bit group, using the standard DES tables S1..S8.
REQ-013 SHALL implement states IDLE, RUN and HOLD.
REQ-014 SHALL in IDLE drive in_ready=1; on accept, capture in_data into a 48-bit input register, clear group index idx to 0 and go to RUN.
REQ-015 SHALL in RUN write lookup(S(idx+1), group idx) into nibble idx of the result register on each edge and increment the 3-bit idx.
REQ-016 SHALL go from RUN to HOLD on the edge that writes idx=7, with no wrap-around processing of group 0.
REQ-017 SHALL, with accept at edge E0, write groups at edges E1..E8 and assert out_valid in the cycle after E8: 8 cycles latency, 10 cycles minimum per block.
REQ-018 SHALL in HOLD drive out_valid=1 and keep out_data stable until out_ready is sampled high, then return to IDLE.
REQ-019 SHALL ignore in_valid and keep the input register unchanged while in RUN or HOLD (in_ready=0).
REQ-020 SHALL hold out_valid for any number of cycles with out_ready=0 and never drop or alter the result.
REQ-021 SHALL drive out_data from the result register only, never from a partially written value; out_data is don't-care while out_valid=0 but holds its last value.
REQ-022 SHALL not accept a new block in the same cycle as a HOLD handshake; the next accept happens no earlier than the following edge in IDLE.

Reset
REQ-023 SHALL on rst_n=0 at an edge force state IDLE, idx=0, input register 0, result register 0, out_valid=0, busy=0 and in_ready=1 from the next cycle on.
REQ-024 SHALL abandon an in-flight block when reset hits during RUN or HOLD, with no out_valid produced for it afterwards.

Structure
REQ-025 SHALL place the state enumeration, the group count (8), the group width (6) and the nibble width (4) in the shared DES package.
REQ-026 SHALL use one combinational sub-module des_sbox_sel (inputs: 3-bit box select, 6-bit group; output: 4-bit value) that holds all eight tables.
REQ-027 SHALL keep the FSM, idx counter and registers in des_sbox_seq, with no combinational path from in_data to out_data.

Verification
REQ-028 SHALL cover: in_data=48'h0, out_ready=1 -> out_valid exactly 8 cycles after accept, out_data=32'hEFA72C4D.
REQ-029 SHALL cover: in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB.
REQ-030 SHALL cover: out_ready held 0 for 20 cycles in HOLD -> out_valid stays 1, out_data unchanged, in_ready 0, a second in_valid is ignored; release -> IDLE next cycle.
REQ-031 SHALL cover: rst_n low for 1 cycle at RUN idx=4 -> IDLE, out_valid 0, no stale result; a new 48'h0 block -> 32'hEFA72C4D.
REQ-032 SHALL cover: back-to-back blocks with in_valid held high and out_ready=1 -> accepts spaced 10 cycles apart, results in order.
REQ-033 SHALL cover: 1000 random blocks compared against a software DES S-box model, with zero mismatches.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: S-box sequencer states and block geometry.
package des_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

    localparam int unsigned NUM_GROUPS = 8;
    localparam int unsigned GROUP_W    = 6;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned IN_W       = NUM_GROUPS * GROUP_W;
    localparam int unsigned OUT_W      = NUM_GROUPS * NIBBLE_W;
    localparam int unsigned IDX_W      = $clog2(NUM_GROUPS);

endpackage

// File: rtl/des_sbox_sel.sv
// Combinational DES S-box lookup: sel picks S1..S8, grp is the 6-bit input group.
module des_sbox_sel
    import des_pkg::*;
(
    input  logic [IDX_W-1:0]    sel,
    input  logic [GROUP_W-1:0]  grp,
    output logic [NIBBLE_W-1:0] value
);

    // Each table lists row 0 col 0 first, so entry {row,col} lives at index ~{row,col}.
    localparam logic [63:0][3:0] S1 =
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [63:0][3:0] S2 =
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [63:0][3:0] S3 =
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [63:0][3:0] S4 =
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [63:0][3:0] S5 =
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [63:0][3:0] S6 =
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [63:0][3:0] S7 =
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [63:0][3:0] S8 =
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    logic [5:0] addr;

    // Row is the outer bit pair, column the inner four bits.
    always_comb begin
        addr  = {grp[5], grp[0], grp[4:1]};
        value = '0;
        unique case (sel)
            3'd0: value = S1[~addr];
            3'd1: value = S2[~addr];
            3'd2: value = S3[~addr];
            3'd3: value = S4[~addr];
            3'd4: value = S5[~addr];
            3'd5: value = S6[~addr];
            3'd6: value = S7[~addr];
            3'd7: value = S8[~addr];
        endcase
    end

endmodule

// File: rtl/des_sbox_seq.sv
// Sequential DES S-box stage: one shared lookup, one 6-bit group per cycle.
module des_sbox_seq
    import des_pkg::*;
#(
    parameter int unsigned DEFAULT_BLOCKING = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    if (DEFAULT_BLOCKING != 1) begin : g_bad_blocking
        $error("des_sbox_seq: only DEFAULT_BLOCKING = 1 is supported");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUPS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IN_W-1:0]      in_q, in_d;
    logic [OUT_W-1:0]     res_q, res_d;
    logic [GROUP_W-1:0]   grp;
    logic [NIBBLE_W-1:0]  sbox_val;
    logic                 accept;

    des_sbox_sel u_sel (
        .sel   (idx_q),
        .grp   (grp),
        .value (sbox_val)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, eight lookups in RUN, wait for consumer in HOLD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)          state_d = StRun;
            StRun:   if (idx_q == LAST_IDX) state_d = StHold;
            StHold:  if (out_ready)         state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StHold);
        busy      = (state_q == StRun) || (state_q == StHold);
        out_data  = res_q;
    end

    // Pick the group addressed by idx; group 0 is the most significant.
    always_comb begin
        grp = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (idx_q == g[IDX_W-1:0]) grp = in_q[IN_W-1-GROUP_W*g -: GROUP_W];
        end
    end

    // Datapath next-state: capture on accept, write one nibble per RUN cycle.
    always_comb begin
        accept = (state_q == StIdle) && in_valid;
        in_d   = in_q;
        idx_d  = idx_q;
        res_d  = res_q;
        if (accept) begin
            in_d  = in_data;
            idx_d = '0;
        end else if (state_q == StRun) begin
            idx_d = idx_q + 1'b1;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (idx_q == g[IDX_W-1:0]) res_d[OUT_W-1-NIBBLE_W*g -: NIBBLE_W] = sbox_val;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            in_q  <= '0;
            res_q <= '0;
        end else begin
            idx_q <= idx_d;
            in_q  <= in_d;
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_des_sbox_seq.sv
// Self-checking bench for des_sbox_seq: directed vectors plus a software S-box model.
module tb_des_sbox_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    des_sbox_seq #(
        .DEFAULT_BLOCKING (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Standard DES S-boxes, row-major (row * 16 + col).
    int sb [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  g6;
        int          row, col;
        r = '0;
        for (int g = 0; g < 8; g++) begin
            g6  = 6'(d >> (42 - 6 * g));
            row = {g6[5], g6[0]};
            col = int'(g6[4:1]);
            r   = (r << 4) | 32'(sb[g][row * 16 + col]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts falling edges until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One block with out_ready high; checks latency and result.
    task automatic send(input logic [47:0] d, input string tag, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_data"}, out_data, exp);
    endtask

    logic [47:0] dvec [4];
    logic [31:0] evec [4];
    logic [47:0] bvec [3];
    logic [31:0] held;
    logic [63:0] rnd;
    logic        seen;
    int          lat, k, r;
    int          acc [3];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;

        // Directed vectors, hand-computed.
        dvec[0] = 48'h000000000000; evec[0] = 32'hEFA72C4D;
        dvec[1] = 48'hFFFFFFFFFFFF; evec[1] = 32'hD9CE3DCB;
        dvec[2] = 48'h041041041041; evec[2] = 32'h03DDEAD1;
        dvec[3] = 48'h820820820820; evec[3] = 32'h40DA4917;
        for (int i = 0; i < 4; i++) send(dvec[i], "directed", evec[i]);

        // Stall in HOLD with a competing in_valid offered throughout.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 48'h0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = 48'hFFFFFFFFFFFF;
        wait_valid(lat);
        check("hold_latency", lat, 8);
        check("hold_data", out_data, 32'hEFA72C4D);
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_stable", out_data, held);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        // in_valid still high across the handshake edge: must not be taken there.
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);
        check("release_keeps_data", out_data, held);
        in_valid = 1'b0;

        // Reset in the middle of RUN (idx = 4).
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 48'hFFFFFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_stale_valid", seen, 0);
        send(48'h0, "after_rst", 32'hEFA72C4D);

        // Back-to-back blocks, in_valid held high.
        bvec[0] = 48'h000000000000;
        bvec[1] = 48'hFFFFFFFFFFFF;
        bvec[2] = 48'h123456789ABC;
        k = 0;
        r = 0;
        acc = '{0, 0, 0};
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_valid = (k < 3);
            if (k < 3) in_data = bvec[k];
            if (out_valid) begin
                if (r < 3) check("b2b_data", out_data, model(bvec[r]));
                r++;
            end
            if (in_ready && in_valid) begin
                acc[k] = c;
                k++;
            end
        end
        in_valid = 1'b0;
        check("b2b_results", r, 3);
        check("b2b_gap1", acc[1] - acc[0], 10);
        check("b2b_gap2", acc[2] - acc[1], 10);

        // Random blocks against the software model.
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom(), $urandom()};
            send(rnd[47:0], "random", model(rnd[47:0]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
